note_sequencer: RTL and testbench
=================================

Name: note_sequencer

Overview:
- Programmable melody controller for the sine tone datapath.
- Holds a small note table: per entry, a 32-bit phase step plus a beat count.
- On start, walks the table and drives the sine generator's frequency step for the required number of audio frames, with a silent articulation gap between notes.
- Sits between the game state machine / keypad logic (start, stop, table writes) and the sine generator's frequency_step input. Timing comes from audio frame pulses.

Parameters:
- notes_p, 16: note table depth (power of two, at least 2).
- ticks_per_beat_p, 6000: audio frames per beat (125 ms at 48 kHz).
- gap_frames_p, 480: silent frames inserted after each note; 0 = no gap.

Ports:
- clk_i  in  1  system clock (audio AXIS clock).
- reset_n_i  in  1  asynchronous active-low reset.
- frame_i  in  1  one-cycle pulse per completed audio frame (tx valid & ready & last).
- start_i  in  1  pulse; begin playback at entry 0.
- stop_i  in  1  pulse; abort playback.
- wr_en_i  in  1  table write strobe.
- wr_addr_i  in  $clog2(notes_p)  table write address.
- wr_fstep_i  in  32  phase step for the entry; 0 = rest.
- wr_beats_i  in  4  note length in beats; 0 = end-of-song marker.
- fstep_o  out  32  frequency step to the sine generator (registered).
- note_idx_o  out  $clog2(notes_p)  entry currently playing.
- busy_o  out  1  high outside IDLE.
- note_start_o  out  1  one-cycle pulse when a note's PLAY begins.
- done_o  out  1  one-cycle pulse on natural song end (not on stop).

Behaviour:
- Reset: state IDLE; fstep_o=0, note_idx_o=0, busy_o=0, note_start_o=0, done_o=0; counters=0.
- Table contents are not reset (inferable as RAM). Software writes the table before start.
- Table write: accepted only in IDLE; wr_en_i while busy_o=1 is ignored. Write takes effect the next cycle.
- States:
  - IDLE: fstep_o=0. start_i moves to LOAD with idx=0.
  - LOAD: one cycle for synchronous table read of entry idx.
  - DECODE: if beats=0, go to END. Otherwise load the frame counter with beats*ticks_per_beat_p, drive fstep_o=entry fstep, pulse note_start_o, go to PLAY.
  - PLAY: decrement on each frame_i. When the counter reaches 0: fstep_o=0, then GAP (if gap_frames_p>0) or NEXT.
  - GAP: fstep_o=0; count gap_frames_p frame_i pulses, then NEXT.
  - NEXT: if idx=notes_p-1, go to END; else idx+1, go to LOAD.
  - END: done_o pulses for one cycle, fstep_o=0, then IDLE.
- Latency: start_i at cycle t gives LOAD at t+1, DECODE at t+2, fstep_o valid and note_start_o high at t+3.
- Frame counting: frame_i is counted only in PLAY and GAP; pulses in other states are ignored. A note of b beats spans exactly b*ticks_per_beat_p frame_i pulses.
- Counter width: $clog2(15*ticks_per_beat_p+1) bits, no overflow possible.
- Rest: fstep=0 with beats≠0 holds silence for the duration and still pulses note_start_o.
- stop_i in any non-IDLE state: next cycle goes to IDLE, fstep_o=0, idx=0, no done_o.
- Priority: stop_i over start_i over frame_i in the same cycle. start_i while busy is ignored.
- Async reset mid-note: immediate IDLE, fstep_o=0.

Optional Feature:
- Macro NOTE_SEQ_LOOP_EN.
- Defined: END does not return to IDLE. It pulses done_o, sets idx=0 and goes to LOAD; playback continues until stop_i. A table whose entry 0 has beats=0 goes to IDLE instead of spinning.
- Undefined: single-shot playback as above.

Decomposition:
- Shared package note_seq_pkg holds:
  - state enum (IDLE, LOAD, DECODE, PLAY, GAP, NEXT, END);
  - typedef note_entry_t {logic [31:0] fstep; logic [3:0] beats;};
  - localparam END_BEATS = 4'd0.
- One sub-module: note_table, a notes_p x 36 single-port-write, synchronous-read RAM (registered read, no reset).

Test Plan:
- Bench parameters: notes_p=4, ticks_per_beat_p=4, gap_frames_p=1.
- Basic song: write {0x1B00D79,1}, {0x201CD60,2}, {x,0}; start, frame every 10 cycles.
  - fstep_o=0x1B00D79 for 4 frames, 0 for 1 frame, 0x201CD60 for 8 frames, then done_o one pulse.
  - note_start_o pulses twice; busy_o low after END.
- Full table wrap: all 4 entries beats=1 → NEXT at idx=3 goes to END (no read past end); done_o=1; note_idx_o sequence 0,1,2,3.
- Stop mid-note: stop_i during the 2nd frame of entry 0 → next cycle fstep_o=0, busy_o=0, no done_o. A restart plays from entry 0 with a full count.
- Write while busy: wr_en_i to addr 0 during PLAY is ignored. Next start replays the original 0x1B00D79.
- Same-cycle events: start_i+stop_i in IDLE stays IDLE. Async reset_n_i low mid-GAP gives all outputs 0 immediately.
- Rest and loop: entry 0 = {0,1}, entry 1 = end marker. fstep_o stays 0 for 4 frames with note_start_o pulsed. With NOTE_SEQ_LOOP_EN, done_o pulses every 5 frames until stop_i.

Source files
------------

// File: rtl/note_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : note_seq_pkg
// Purpose  : Shared state encoding, note-table entry layout and constants.
// Revision : 1.0 - initial release
// ============================================================================
package note_seq_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_DECODE = 3'd2,
        S_PLAY   = 3'd3,
        S_GAP    = 3'd4,
        S_NEXT   = 3'd5,
        S_END    = 3'd6
    } seq_state_t;

    typedef struct packed {
        logic [31:0] fstep;
        logic [3:0]  beats;
    } note_entry_t;

    localparam int         NOTE_W    = 36;
    localparam logic [3:0] END_BEATS = 4'd0;

endpackage
`default_nettype wire

// File: rtl/note_sequencer_table.sv
`default_nettype none
// ============================================================================
// Module   : note_table
// Purpose  : notes_p x 36 RAM, single write port, registered read, no reset.
// Revision : 1.0 - initial release
// ============================================================================
module note_table
    import note_seq_pkg::*;
#(
    parameter int notes_p = 16
) (
    input  logic                       clk_i,
    input  logic                       wr_en_i,
    input  logic [$clog2(notes_p)-1:0] wr_addr_i,
    input  logic [NOTE_W-1:0]          wr_data_i,
    input  logic [$clog2(notes_p)-1:0] rd_addr_i,
    output logic [NOTE_W-1:0]          rd_data_o
);

    logic [NOTE_W-1:0] mem_q [notes_p];
    logic [NOTE_W-1:0] rd_q;

    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
        rd_q <= mem_q[rd_addr_i];
    end

    assign rd_data_o = rd_q;

endmodule
`default_nettype wire

// File: rtl/note_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : note_sequencer
// Purpose  : Walks a note table and drives the sine generator phase step,
//            timed by audio frame pulses. Optional: NOTE_SEQ_LOOP_EN.
// Revision : 1.0 - initial release
// ============================================================================
module note_sequencer
    import note_seq_pkg::*;
#(
    parameter int notes_p          = 16,
    parameter int ticks_per_beat_p = 6000,
    parameter int gap_frames_p     = 480
) (
    input  logic                       clk_i,
    input  logic                       reset_n_i,
    input  logic                       frame_i,
    input  logic                       start_i,
    input  logic                       stop_i,
    input  logic                       wr_en_i,
    input  logic [$clog2(notes_p)-1:0] wr_addr_i,
    input  logic [31:0]                wr_fstep_i,
    input  logic [3:0]                 wr_beats_i,
    output logic [31:0]                fstep_o,
    output logic [$clog2(notes_p)-1:0] note_idx_o,
    output logic                       busy_o,
    output logic                       note_start_o,
    output logic                       done_o
);

    localparam int IDX_W      = $clog2(notes_p);
    localparam int NOTE_CNT_W = $clog2(15 * ticks_per_beat_p + 1);
    localparam int GAP_CNT_W  = $clog2(gap_frames_p + 1);
    localparam int CNT_W      = (NOTE_CNT_W > GAP_CNT_W) ? NOTE_CNT_W : GAP_CNT_W;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(notes_p - 1);
    localparam logic [CNT_W-1:0] TICKS_C  = CNT_W'(ticks_per_beat_p);
    localparam logic [CNT_W-1:0] GAP_C    = CNT_W'(gap_frames_p);
    localparam logic [CNT_W-1:0] ONE_C    = CNT_W'(1);

    seq_state_t        state_q;
    logic [31:0]       fstep_q;
    logic [IDX_W-1:0]  idx_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              note_start_q;
    logic              done_q;

    logic              w_wr_en;
    logic [NOTE_W-1:0] w_rd_raw;
    note_entry_t       w_rd_entry;

    // Writes are only honoured while idle so a playing song cannot be torn.
    assign w_wr_en    = wr_en_i && (state_q == S_IDLE);
    assign w_rd_entry = note_entry_t'(w_rd_raw);

    note_table #(
        .notes_p   (notes_p)
    ) u_note_table (
        .clk_i     (clk_i),
        .wr_en_i   (w_wr_en),
        .wr_addr_i (wr_addr_i),
        .wr_data_i ({wr_fstep_i, wr_beats_i}),
        .rd_addr_i (idx_q),
        .rd_data_o (w_rd_raw)
    );

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q      <= S_IDLE;
            fstep_q      <= '0;
            idx_q        <= '0;
            cnt_q        <= '0;
            note_start_q <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            note_start_q <= 1'b0;
            done_q       <= 1'b0;
            if (stop_i && (state_q != S_IDLE)) begin
                state_q <= S_IDLE;
                fstep_q <= '0;
                idx_q   <= '0;
                cnt_q   <= '0;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        fstep_q <= '0;
                        if (start_i && !stop_i) begin
                            idx_q   <= '0;
                            state_q <= S_LOAD;
                        end
                    end
                    S_LOAD: begin
                        state_q <= S_DECODE;
                    end
                    S_DECODE: begin
                        if (w_rd_entry.beats == END_BEATS) begin
                            fstep_q <= '0;
                            done_q  <= 1'b1;
                            state_q <= S_END;
                        end else begin
                            cnt_q        <= CNT_W'(w_rd_entry.beats) * TICKS_C;
                            fstep_q      <= w_rd_entry.fstep;
                            note_start_q <= 1'b1;
                            state_q      <= S_PLAY;
                        end
                    end
                    S_PLAY: begin
                        if (frame_i) begin
                            cnt_q <= cnt_q - ONE_C;
                            if (cnt_q == ONE_C) begin
                                fstep_q <= '0;
                                if (gap_frames_p > 0) begin
                                    cnt_q   <= GAP_C;
                                    state_q <= S_GAP;
                                end else begin
                                    state_q <= S_NEXT;
                                end
                            end
                        end
                    end
                    S_GAP: begin
                        fstep_q <= '0;
                        if (frame_i) begin
                            cnt_q <= cnt_q - ONE_C;
                            if (cnt_q == ONE_C) begin
                                state_q <= S_NEXT;
                            end
                        end
                    end
                    S_NEXT: begin
                        if (idx_q == LAST_IDX) begin
                            done_q  <= 1'b1;
                            state_q <= S_END;
                        end else begin
                            idx_q   <= idx_q + 1'b1;
                            state_q <= S_LOAD;
                        end
                    end
                    S_END: begin
                        fstep_q <= '0;
`ifdef NOTE_SEQ_LOOP_EN
                        // END at index 0 means entry 0 is the end marker: park instead of spinning.
                        if (idx_q == '0) begin
                            state_q <= S_IDLE;
                        end else begin
                            idx_q   <= '0;
                            state_q <= S_LOAD;
                        end
`else
                        idx_q   <= '0;
                        state_q <= S_IDLE;
`endif
                    end
                    default: begin
                        state_q <= S_IDLE;
                        fstep_q <= '0;
                        idx_q   <= '0;
                    end
                endcase
            end
        end
    end

    assign fstep_o      = fstep_q;
    assign note_idx_o   = idx_q;
    assign busy_o       = (state_q != S_IDLE);
    assign note_start_o = note_start_q;
    assign done_o       = done_q;

endmodule
`default_nettype wire

// File: tb/tb_note_sequencer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_note_sequencer
// Purpose  : Self-checking bench for note_sequencer (4 entries, 4 frames/beat,
//            1 gap frame). Loop-mode section uses NOTE_SEQ_LOOP_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_note_sequencer;

    localparam logic [31:0] F1 = 32'h01B0_0D79;
    localparam logic [31:0] F2 = 32'h0201_CD60;

    logic        clk_i = 1'b0;
    logic        reset_n_i;
    logic        frame_i, start_i, stop_i, wr_en_i;
    logic [1:0]  wr_addr_i;
    logic [31:0] wr_fstep_i;
    logic [3:0]  wr_beats_i;
    logic [31:0] fstep_o;
    logic [1:0]  note_idx_o;
    logic        busy_o, note_start_o, done_o;

    int checks = 0;
    int errors = 0;
    int f1, f2, z, oth, ns, dn, hist;
    logic to;

    typedef struct {
        logic        st, sp, fr;
        logic [31:0] fstep;
        logic [1:0]  idx;
        logic        busy, ns, done;
    } vec_t;
    vec_t vecs[$];

    note_sequencer #(
        .notes_p          (4),
        .ticks_per_beat_p (4),
        .gap_frames_p     (1)
    ) dut (
        .clk_i        (clk_i),
        .reset_n_i    (reset_n_i),
        .frame_i      (frame_i),
        .start_i      (start_i),
        .stop_i       (stop_i),
        .wr_en_i      (wr_en_i),
        .wr_addr_i    (wr_addr_i),
        .wr_fstep_i   (wr_fstep_i),
        .wr_beats_i   (wr_beats_i),
        .fstep_o      (fstep_o),
        .note_idx_o   (note_idx_o),
        .busy_o       (busy_o),
        .note_start_o (note_start_o),
        .done_o       (done_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic vec_t mk(input logic st, input logic sp, input logic fr,
                                input logic [31:0] f, input logic [1:0] i,
                                input logic b, input logic n, input logic d);
        vec_t v;
        v.st = st; v.sp = sp; v.fr = fr; v.fstep = f; v.idx = i;
        v.busy = b; v.ns = n; v.done = d;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick(input logic st, input logic sp, input logic fr);
        @(negedge clk_i);
        start_i = st; stop_i = sp; frame_i = fr; wr_en_i = 1'b0;
        @(posedge clk_i);
        #1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] f, input logic [3:0] b);
        @(negedge clk_i);
        start_i = 1'b0; stop_i = 1'b0; frame_i = 1'b0;
        wr_en_i = 1'b1; wr_addr_i = a; wr_fstep_i = f; wr_beats_i = b;
        @(posedge clk_i);
        #1;
        wr_en_i = 1'b0;
    endtask

    // Plays one pass with a frame every 'period' cycles, tallying frames by output step.
    task automatic run_song(input int period);
        f1 = 0; f2 = 0; z = 0; oth = 0; ns = 0; dn = 0; hist = 0; to = 1'b1;
        tick(1'b1, 1'b0, 1'b0);
        for (int c = 0; c < 1000; c++) begin
            @(negedge clk_i);
            start_i = 1'b0; stop_i = 1'b0; wr_en_i = 1'b0;
            frame_i = ((c % period) == (period - 1));
            if (frame_i && busy_o) begin
                if (fstep_o == F1)      f1++;
                else if (fstep_o == F2) f2++;
                else if (fstep_o == 0)  z++;
                else                    oth++;
            end
            @(posedge clk_i);
            #1;
            if (note_start_o) begin
                ns++;
                hist = hist * 10 + int'(note_idx_o) + 1;
            end
            if (done_o) dn++;
            if (done_o || !busy_o) begin
                to = 1'b0;
                break;
            end
        end
        tick(1'b0, 1'b0, 1'b0);
        if (busy_o) tick(1'b0, 1'b1, 1'b0);
    endtask

    task automatic expect_song(input string tag, input int ef1, input int ef2, input int ez,
                               input int eoth, input int ens, input int edn, input int ehist);
        chk({tag, " timeout"}, 32'(to), 32'd0);
        chk({tag, " frames_f1"}, 32'(f1), 32'(ef1));
        chk({tag, " frames_f2"}, 32'(f2), 32'(ef2));
        chk({tag, " frames_zero"}, 32'(z), 32'(ez));
        chk({tag, " frames_other"}, 32'(oth), 32'(eoth));
        chk({tag, " note_starts"}, 32'(ns), 32'(ens));
        chk({tag, " dones"}, 32'(dn), 32'(edn));
        chk({tag, " idx_history"}, 32'(hist), 32'(ehist));
        chk({tag, " busy_after"}, 32'(busy_o), 32'd0);
    endtask

    initial begin
        reset_n_i = 1'b0;
        frame_i = 1'b0; start_i = 1'b0; stop_i = 1'b0; wr_en_i = 1'b0;
        wr_addr_i = '0; wr_fstep_i = '0; wr_beats_i = '0;

        // Dense-frame cycle table for the basic song: {start,stop,frame} -> outputs.
        vecs.push_back(mk(1, 0, 0, 0,  0, 1, 0, 0));
        vecs.push_back(mk(0, 0, 1, 0,  0, 1, 0, 0));
        vecs.push_back(mk(0, 0, 1, F1, 0, 1, 1, 0));
        repeat (3) vecs.push_back(mk(0, 0, 1, F1, 0, 1, 0, 0));
        repeat (2) vecs.push_back(mk(0, 0, 1, 0,  0, 1, 0, 0));
        repeat (2) vecs.push_back(mk(0, 0, 1, 0,  1, 1, 0, 0));
        vecs.push_back(mk(0, 0, 1, F2, 1, 1, 1, 0));
        repeat (7) vecs.push_back(mk(0, 0, 1, F2, 1, 1, 0, 0));
        repeat (2) vecs.push_back(mk(0, 0, 1, 0,  1, 1, 0, 0));
        repeat (2) vecs.push_back(mk(0, 0, 1, 0,  2, 1, 0, 0));
        vecs.push_back(mk(0, 0, 1, 0,  2, 1, 0, 1));
`ifdef NOTE_SEQ_LOOP_EN
        vecs.push_back(mk(0, 0, 0, 0,  0, 1, 0, 0));
`else
        vecs.push_back(mk(0, 0, 0, 0,  0, 0, 0, 0));
`endif
        vecs.push_back(mk(0, 1, 0, 0,  0, 0, 0, 0));

        repeat (3) @(posedge clk_i);
        #1;
        chk("reset fstep", fstep_o, 32'd0);
        chk("reset idx", 32'(note_idx_o), 32'd0);
        chk("reset busy", 32'(busy_o), 32'd0);
        chk("reset note_start", 32'(note_start_o), 32'd0);
        chk("reset done", 32'(done_o), 32'd0);
        @(negedge clk_i);
        reset_n_i = 1'b1;

        wr(2'd0, F1, 4'd1);
        wr(2'd1, F2, 4'd2);
        wr(2'd2, 32'hDEAD_BEEF, 4'd0);
        wr(2'd3, 32'hCAFE_F00D, 4'd0);

        for (int i = 0; i < vecs.size(); i++) begin
            tick(vecs[i].st, vecs[i].sp, vecs[i].fr);
            chk($sformatf("vec%0d fstep", i), fstep_o, vecs[i].fstep);
            chk($sformatf("vec%0d idx", i), 32'(note_idx_o), 32'(vecs[i].idx));
            chk($sformatf("vec%0d busy", i), 32'(busy_o), 32'(vecs[i].busy));
            chk($sformatf("vec%0d note_start", i), 32'(note_start_o), 32'(vecs[i].ns));
            chk($sformatf("vec%0d done", i), 32'(done_o), 32'(vecs[i].done));
        end

        run_song(10);
        expect_song("basic", 4, 8, 2, 0, 2, 1, 12);

        // Stop during the second frame of entry 0, then restart from scratch.
        tick(1'b1, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b0);
        chk("stop pre note_start", 32'(note_start_o), 32'd1);
        tick(1'b0, 1'b0, 1'b1);
        tick(1'b0, 1'b1, 1'b1);
        chk("stop fstep", fstep_o, 32'd0);
        chk("stop busy", 32'(busy_o), 32'd0);
        chk("stop idx", 32'(note_idx_o), 32'd0);
        chk("stop done", 32'(done_o), 32'd0);
        tick(1'b0, 1'b0, 1'b0);
        chk("stop done late", 32'(done_o), 32'd0);
        run_song(1);
        expect_song("restart", 4, 8, 10, 0, 2, 1, 12);

        // Table write during PLAY must be dropped.
        tick(1'b1, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b0);
        chk("wrbusy playing", 32'(busy_o), 32'd1);
        wr(2'd0, 32'h1234_5678, 4'd3);
        tick(1'b0, 1'b1, 1'b0);
        chk("wrbusy stopped", 32'(busy_o), 32'd0);
        run_song(10);
        expect_song("wrbusy", 4, 8, 2, 0, 2, 1, 12);

        tick(1'b1, 1'b1, 1'b0);
        chk("start+stop busy", 32'(busy_o), 32'd0);
        chk("start+stop fstep", fstep_o, 32'd0);
        tick(1'b0, 1'b0, 1'b0);
        chk("start+stop busy later", 32'(busy_o), 32'd0);

        // Asynchronous reset while in the gap after entry 1.
        tick(1'b1, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b0);
        chk("areset note1 fstep", fstep_o, F1);
        repeat (4) tick(1'b0, 1'b0, 1'b1);
        chk("areset gap1 fstep", fstep_o, 32'd0);
        chk("areset gap1 busy", 32'(busy_o), 32'd1);
        repeat (4) tick(1'b0, 1'b0, 1'b1);
        chk("areset note2 fstep", fstep_o, F2);
        chk("areset note2 start", 32'(note_start_o), 32'd1);
        repeat (8) tick(1'b0, 1'b0, 1'b1);
        chk("areset gap2 busy", 32'(busy_o), 32'd1);
        chk("areset gap2 idx", 32'(note_idx_o), 32'd1);
        @(negedge clk_i);
        frame_i = 1'b0;
        #2;
        reset_n_i = 1'b0;
        #1;
        chk("areset fstep", fstep_o, 32'd0);
        chk("areset busy", 32'(busy_o), 32'd0);
        chk("areset idx", 32'(note_idx_o), 32'd0);
        chk("areset note_start", 32'(note_start_o), 32'd0);
        chk("areset done", 32'(done_o), 32'd0);
        @(negedge clk_i);
        reset_n_i = 1'b1;

        wr(2'd0, F1, 4'd1);
        wr(2'd1, F2, 4'd1);
        wr(2'd2, 32'h0000_0003, 4'd1);
        wr(2'd3, 32'h0000_0004, 4'd1);
        run_song(10);
        expect_song("wrap", 4, 4, 4, 8, 4, 1, 1234);

        wr(2'd0, 32'd0, 4'd1);
        wr(2'd1, 32'hDEAD_BEEF, 4'd0);
        run_song(10);
        expect_song("rest", 0, 0, 5, 0, 1, 1, 1);

`ifdef NOTE_SEQ_LOOP_EN
        begin
            int nd = 0;
            int fr = 0;
            tick(1'b1, 1'b0, 1'b0);
            for (int c = 0; c < 400 && nd < 3; c++) begin
                @(negedge clk_i);
                start_i = 1'b0;
                frame_i = ((c % 10) == 9);
                if (frame_i && busy_o) fr++;
                @(posedge clk_i);
                #1;
                if (done_o) begin
                    nd++;
                    chk($sformatf("loop frames per pass %0d", nd), 32'(fr), 32'd5);
                    fr = 0;
                end
            end
            chk("loop dones", 32'(nd), 32'd3);
            tick(1'b0, 1'b1, 1'b0);
            chk("loop stop busy", 32'(busy_o), 32'd0);
            chk("loop stop done", 32'(done_o), 32'd0);
        end
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
